// File: rtl/rob_multiport.sv
// rob_multiport: reorder buffer with in-order alloc, multi-port writeback, multi-lane in-order commit, rd hazard lookup.
// Optional ROB_EXT_FLUSH_EN adds flush_i, an external flush request.
module rob_multiport #(
  parameter int DEPTH    = 16,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
`ifdef ROB_EXT_FLUSH_EN
  input  logic                          flush_i,
`endif
  input  logic                          alloc_valid_i,
  output logic                          alloc_ready_o,
  input  logic [31:0]                   alloc_pc_i,
  input  logic [31:0]                   alloc_instr_i,
  input  logic [4:0]                    alloc_rd_i,
  input  logic                          alloc_we_i,
  input  logic                          alloc_store_i,
  output logic [$clog2(DEPTH)-1:0]      alloc_idx_o,
  input  logic [WB_PORTS-1:0]           wb_valid_i,
  input  logic [WB_PORTS*$clog2(DEPTH)-1:0] wb_idx_i,
  input  logic [WB_PORTS*32-1:0]        wb_result_i,
  input  logic [WB_PORTS*32-1:0]        wb_new_pc_i,
  input  logic [WB_PORTS-1:0]           wb_taken_i,
  output logic [COMMIT_W-1:0]           cm_valid_o,
  output logic [COMMIT_W*32-1:0]        cm_pc_o,
  output logic [COMMIT_W*32-1:0]        cm_instr_o,
  output logic [COMMIT_W*32-1:0]        cm_result_o,
  output logic [COMMIT_W*32-1:0]        cm_new_pc_o,
  output logic [COMMIT_W*5-1:0]         cm_rd_o,
  output logic [COMMIT_W-1:0]           cm_we_o,
  output logic [COMMIT_W-1:0]           cm_store_o,
  output logic [COMMIT_W-1:0]           cm_taken_o,
  output logic [$clog2(DEPTH):0]        count_o,
  input  logic [4:0]                    rs1_i,
  input  logic [4:0]                    rs2_i,
  output logic                          hz_rs1_hit_o,
  output logic [$clog2(DEPTH)-1:0]      hz_rs1_idx_o,
  output logic                          hz_rs1_done_o,
  output logic [31:0]                   hz_rs1_data_o,
  output logic                          hz_rs2_hit_o,
  output logic [$clog2(DEPTH)-1:0]      hz_rs2_idx_o,
  output logic                          hz_rs2_done_o,
  output logic [31:0]                   hz_rs2_data_o
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             done;
    logic [31:0]      data;
  } hz_t;
  logic [DEPTH-1:0] valid, done, we, store, taken;
  logic [31:0]      pc [DEPTH];
  logic [31:0]      instr [DEPTH];
  logic [31:0]      result [DEPTH];
  logic [31:0]      new_pc [DEPTH];
  logic [4:0]       rd [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0]   count, n_commit;
  logic [IDX_W-1:0] widx [WB_PORTS];
  logic             fire, flush, ext, ok;
  hz_t              h1, h2;
`ifdef ROB_EXT_FLUSH_EN
  assign ext = flush_i;
`else
  assign ext = 1'b0;
`endif
  for (genvar p = 0; p < WB_PORTS; p++) begin : g_widx
    assign widx[p] = wb_idx_i[p*IDX_W +: IDX_W];
  end
  assign alloc_ready_o = (count < (IDX_W+1)'(DEPTH)) && !flush;
  assign fire          = alloc_valid_i && alloc_ready_o;
  assign alloc_idx_o   = tail;
  assign count_o       = count;
  // A lane retires only if every older lane retired and none of them redirected.
  always_comb begin
    ok          = 1'b1;
    n_commit    = '0;
    flush       = ext;
    cm_valid_o  = '0;
    cm_pc_o     = '0;
    cm_instr_o  = '0;
    cm_result_o = '0;
    cm_new_pc_o = '0;
    cm_rd_o     = '0;
    cm_we_o     = '0;
    cm_store_o  = '0;
    cm_taken_o  = '0;
    for (int j = 0; j < COMMIT_W; j++) begin
      cm_valid_o[j] = ok && valid[head + IDX_W'(j)] && done[head + IDX_W'(j)] && ((IDX_W+1)'(j) < count);
      ok = cm_valid_o[j] && !taken[head + IDX_W'(j)];
      if (cm_valid_o[j]) begin
        n_commit               = n_commit + (IDX_W+1)'(1);
        flush                  = flush | taken[head + IDX_W'(j)];
        cm_pc_o[j*32 +: 32]     = pc[head + IDX_W'(j)];
        cm_instr_o[j*32 +: 32]  = instr[head + IDX_W'(j)];
        cm_result_o[j*32 +: 32] = result[head + IDX_W'(j)];
        cm_new_pc_o[j*32 +: 32] = new_pc[head + IDX_W'(j)];
        cm_rd_o[j*5 +: 5]       = rd[head + IDX_W'(j)];
        cm_we_o[j]              = we[head + IDX_W'(j)];
        cm_store_o[j]           = store[head + IDX_W'(j)];
        cm_taken_o[j]           = taken[head + IDX_W'(j)];
      end
    end
  end
  // Valid entries are contiguous from head, so the last match in age order is the youngest producer.
  function automatic hz_t lookup(input logic [4:0] rs);
    hz_t h;
    h = '0;
    for (int k = 0; k < DEPTH; k++)
      if (valid[head + IDX_W'(k)] && we[head + IDX_W'(k)] && rd[head + IDX_W'(k)] == rs && rs != 5'd0) begin
        h.hit = 1'b1;
        h.idx = head + IDX_W'(k);
      end
    if (h.hit) begin
      h.done = done[h.idx];
      h.data = done[h.idx] ? result[h.idx] : 32'd0;
    end
    return h;
  endfunction
  always_comb begin
    h1 = lookup(rs1_i);
    h2 = lookup(rs2_i);
  end
  assign {hz_rs1_hit_o, hz_rs1_idx_o, hz_rs1_done_o, hz_rs1_data_o} = h1;
  assign {hz_rs2_hit_o, hz_rs2_idx_o, hz_rs2_done_o, hz_rs2_data_o} = h2;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int j = 0; j < COMMIT_W; j++)
        if (cm_valid_o[j]) valid[head + IDX_W'(j)] <= 1'b0;
      if (fire) valid[tail] <= 1'b1;
      head  <= head + n_commit[IDX_W-1:0];
      tail  <= tail + IDX_W'(fire);
      count <= count + (IDX_W+1)'(fire) - n_commit;
    end
  end
  // Payload needs no reset: every read is qualified by valid, and alloc clears done.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      pc[tail]    <= alloc_pc_i;
      instr[tail] <= alloc_instr_i;
      rd[tail]    <= alloc_rd_i;
      we[tail]    <= alloc_we_i;
      store[tail] <= alloc_store_i;
      done[tail]  <= 1'b0;
      taken[tail] <= 1'b0;
    end
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_valid_i[p] && valid[widx[p]]) begin
        done[widx[p]]   <= 1'b1;
        result[widx[p]] <= wb_result_i[p*32 +: 32];
        new_pc[widx[p]] <= wb_new_pc_i[p*32 +: 32];
        taken[widx[p]]  <= wb_taken_i[p];
      end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed self-checking bench for rob_multiport (DEPTH=16, WB_PORTS=2, COMMIT_W=2).
module tb_rob_multiport;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_valid, alloc_ready, alloc_we, alloc_store;
  logic [31:0] alloc_pc, alloc_instr;
  logic [4:0]  alloc_rd, rs1, rs2;
  logic [3:0]  alloc_idx, hz1_idx, hz2_idx;
  logic [1:0]  wb_valid, wb_taken;
  logic [7:0]  wb_idx;
  logic [63:0] wb_result, wb_new_pc;
  logic [1:0]  cm_valid, cm_we, cm_store, cm_taken;
  logic [63:0] cm_pc, cm_instr, cm_result, cm_new_pc;
  logic [9:0]  cm_rd;
  logic [4:0]  count;
  logic        hz1_hit, hz1_done, hz2_hit, hz2_done;
  logic [31:0] hz1_data, hz2_data;
  int          vecs = 0;
  int          errs = 0;
  always #5 clk = ~clk;
  rob_multiport #(.DEPTH(16), .WB_PORTS(2), .COMMIT_W(2)) dut (
    .clk_i(clk), .rstn_i(rstn),
`ifdef ROB_EXT_FLUSH_EN
    .flush_i(flush),
`endif
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_pc_i(alloc_pc),
    .alloc_instr_i(alloc_instr), .alloc_rd_i(alloc_rd), .alloc_we_i(alloc_we),
    .alloc_store_i(alloc_store), .alloc_idx_o(alloc_idx),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_result_i(wb_result),
    .wb_new_pc_i(wb_new_pc), .wb_taken_i(wb_taken),
    .cm_valid_o(cm_valid), .cm_pc_o(cm_pc), .cm_instr_o(cm_instr), .cm_result_o(cm_result),
    .cm_new_pc_o(cm_new_pc), .cm_rd_o(cm_rd), .cm_we_o(cm_we), .cm_store_o(cm_store),
    .cm_taken_o(cm_taken), .count_o(count), .rs1_i(rs1), .rs2_i(rs2),
    .hz_rs1_hit_o(hz1_hit), .hz_rs1_idx_o(hz1_idx), .hz_rs1_done_o(hz1_done), .hz_rs1_data_o(hz1_data),
    .hz_rs2_hit_o(hz2_hit), .hz_rs2_idx_o(hz2_idx), .hz_rs2_done_o(hz2_done), .hz_rs2_data_o(hz2_data)
  );
  always @(posedge clk)
    if (rstn && wb_valid == 2'b11)
      assert (wb_idx[3:0] != wb_idx[7:4]) else $error("two writeback ports target index %0d", wb_idx[3:0]);
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    alloc_valid = 0; alloc_pc = 0; alloc_instr = 0; alloc_rd = 0; alloc_we = 0; alloc_store = 0;
    wb_valid = 0; wb_idx = 0; wb_result = 0; wb_new_pc = 0; wb_taken = 0;
    rs1 = 0; rs2 = 0; flush = 0;
  endtask
  task automatic do_reset();
    clear_in();
    rstn = 0;
    step();
    step();
    rstn = 1;
  endtask
  task automatic alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we);
    alloc_valid = 1; alloc_pc = pc; alloc_instr = pc ^ 32'hA5A5_0000; alloc_rd = rd; alloc_we = we;
    step();
    alloc_valid = 0;
  endtask
  task automatic wb(input logic [3:0] idx, input logic [31:0] res, input logic tk, input logic [31:0] npc);
    wb_valid = 2'b01; wb_idx = {4'd0, idx}; wb_result = {32'd0, res}; wb_taken = {1'b0, tk}; wb_new_pc = {32'd0, npc};
    step();
    wb_valid = 0;
  endtask
  task automatic test_reset();
    clear_in();
    rstn = 0;
    #3;
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %0b want 1", alloc_ready); end
    vecs++; if (cm_valid !== 2'b00 || hz1_hit !== 1'b0) begin errs++; $display("FAIL reset_outputs: cm_valid %b hit %b want 00 0", cm_valid, hz1_hit); end
    step();
    rstn = 1;
  endtask
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1; alloc_pc = 32'h1000 + 32'(4 * i); alloc_rd = 5'(i); alloc_we = 0;
      vecs++; if (alloc_idx !== 4'(i)) begin errs++; $display("FAIL fill_idx: got %0d want %0d", alloc_idx, i); end
      step();
    end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_count: got %0d want 16", count); end
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL fill_ready: got %0b want 0", alloc_ready); end
    step();
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_held: got %0d want 16", count); end
    wb(4'd0, 32'h77, 1'b0, 32'h1004);
    vecs++; if (cm_valid !== 2'b01) begin errs++; $display("FAIL fill_commit: got %b want 01", cm_valid); end
    vecs++; if (cm_pc[31:0] !== 32'h1000) begin errs++; $display("FAIL fill_cm_pc: got %h want 00001000", cm_pc[31:0]); end
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL fill_ready_commit: got %0b want 0", alloc_ready); end
    step();
    vecs++; if (count !== 5'd15) begin errs++; $display("FAIL fill_after_commit: got %0d want 15", count); end
    vecs++; if (alloc_ready !== 1'b1) begin errs++; $display("FAIL fill_ready_again: got %0b want 1", alloc_ready); end
    vecs++; if (alloc_idx !== 4'd0) begin errs++; $display("FAIL fill_wrap_idx: got %0d want 0", alloc_idx); end
    step();
    alloc_valid = 0;
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_refill: got %0d want 16", count); end
  endtask
  task automatic test_dual_commit();
    do_reset();
    alloc(32'h200, 5'd1, 1'b1);
    alloc(32'h204, 5'd2, 1'b1);
    alloc(32'h208, 5'd3, 1'b1);
    vecs++; if (count !== 5'd3) begin errs++; $display("FAIL dual_count3: got %0d want 3", count); end
    wb(4'd2, 32'h22, 1'b0, 32'h20c);
    vecs++; if (cm_valid !== 2'b00) begin errs++; $display("FAIL dual_wait_head: got %b want 00", cm_valid); end
    wb_valid = 2'b11; wb_idx = {4'd1, 4'd0}; wb_result = {32'h11, 32'h10}; wb_taken = 2'b00;
    wb_new_pc = {32'h208, 32'h204};
    step();
    wb_valid = 0;
    vecs++; if (cm_valid !== 2'b11) begin errs++; $display("FAIL dual_lanes: got %b want 11", cm_valid); end
    vecs++; if (cm_pc !== {32'h204, 32'h200}) begin errs++; $display("FAIL dual_pc: got %h want 0000020400000200", cm_pc); end
    vecs++; if (cm_result !== {32'h11, 32'h10}) begin errs++; $display("FAIL dual_result: got %h want 0000001100000010", cm_result); end
    vecs++; if (cm_rd !== {5'd2, 5'd1} || cm_we !== 2'b11) begin errs++; $display("FAIL dual_rd_we: got %h %b want 041 11", cm_rd, cm_we); end
    step();
    vecs++; if (cm_valid !== 2'b01 || cm_pc[31:0] !== 32'h208) begin errs++; $display("FAIL dual_lane0_a2: got %b %h want 01 00000208", cm_valid, cm_pc[31:0]); end
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL dual_count1: got %0d want 1", count); end
    step();
    vecs++; if (count !== 5'd0 || cm_valid !== 2'b00) begin errs++; $display("FAIL dual_empty: got %0d %b want 0 00", count, cm_valid); end
  endtask
  task automatic test_taken_branch();
    do_reset();
    alloc(32'h40, 5'd1, 1'b1);
    alloc(32'h44, 5'd2, 1'b1);
    wb_valid = 2'b11; wb_idx = {4'd1, 4'd0}; wb_result = {32'h2, 32'h1}; wb_taken = 2'b01;
    wb_new_pc = {32'h48, 32'h100};
    step();
    wb_valid = 0;
    vecs++; if (cm_valid !== 2'b01) begin errs++; $display("FAIL br_lanes: got %b want 01", cm_valid); end
    vecs++; if (cm_taken !== 2'b01 || cm_new_pc[31:0] !== 32'h100) begin errs++; $display("FAIL br_redirect: got %b %h want 01 00000100", cm_taken, cm_new_pc[31:0]); end
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL br_ready: got %0b want 0", alloc_ready); end
    step();
    vecs++; if (count !== 5'd0 || alloc_idx !== 4'd0) begin errs++; $display("FAIL br_flushed: got count %0d idx %0d want 0 0", count, alloc_idx); end
    vecs++; if (cm_valid !== 2'b00 || alloc_ready !== 1'b1) begin errs++; $display("FAIL br_after: got %b %0b want 00 1", cm_valid, alloc_ready); end
  endtask
  task automatic test_hazard();
    do_reset();
    alloc(32'h80, 5'd5, 1'b1);
    alloc(32'h84, 5'd5, 1'b1);
    alloc(32'h88, 5'd0, 1'b1);
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    vecs++; if (hz1_hit !== 1'b1 || hz1_idx !== 4'd1) begin errs++; $display("FAIL hz_youngest: got hit %0b idx %0d want 1 1", hz1_hit, hz1_idx); end
    vecs++; if (hz1_done !== 1'b0) begin errs++; $display("FAIL hz_pending: got %0b want 0", hz1_done); end
    vecs++; if (hz2_hit !== 1'b0) begin errs++; $display("FAIL hz_x0: got %0b want 0", hz2_hit); end
    wb(4'd1, 32'hDEAD, 1'b0, 32'h88);
    vecs++; if (hz1_done !== 1'b1 || hz1_data !== 32'hDEAD) begin errs++; $display("FAIL hz_done: got %0b %h want 1 0000dead", hz1_done, hz1_data); end
    vecs++; if (cm_valid !== 2'b00) begin errs++; $display("FAIL hz_no_commit: got %b want 00", cm_valid); end
    rs2 = 5'd7;
    #1;
    vecs++; if (hz2_hit !== 1'b0 || hz2_idx !== 4'd0) begin errs++; $display("FAIL hz_miss: got %0b %0d want 0 0", hz2_hit, hz2_idx); end
  endtask
  task automatic test_stale_wb();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(4 * i), 5'(i + 1), 1'b1);
    wb(4'd0, 32'h1, 1'b1, 32'h500);
    vecs++; if (cm_valid !== 2'b01 || cm_taken !== 2'b01) begin errs++; $display("FAIL stale_branch: got %b %b want 01 01", cm_valid, cm_taken); end
    step();
    wb(4'd3, 32'h33, 1'b0, 32'h310);
    rs1 = 5'd4;
    #1;
    vecs++; if (cm_valid !== 2'b00 || count !== 5'd0) begin errs++; $display("FAIL stale_ignored: got %b %0d want 00 0", cm_valid, count); end
    vecs++; if (hz1_hit !== 1'b0) begin errs++; $display("FAIL stale_hz: got %0b want 0", hz1_hit); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) alloc(32'h600 + 32'(4 * i), 5'(i + 1), 1'b1);
    rs1 = 5'd3;
    #1;
    vecs++; if (count !== 5'd7 || hz1_hit !== 1'b1) begin errs++; $display("FAIL mid_before: got %0d %0b want 7 1", count, hz1_hit); end
    wb_valid = 2'b01; wb_idx = 8'd0; wb_result = 64'h5;
    #2;
    rstn = 0;
    #1;
    vecs++; if (count !== 5'd0 || alloc_ready !== 1'b1) begin errs++; $display("FAIL mid_reset: got %0d %0b want 0 1", count, alloc_ready); end
    vecs++; if (cm_valid !== 2'b00 || hz1_hit !== 1'b0) begin errs++; $display("FAIL mid_outputs: got %b %0b want 00 0", cm_valid, hz1_hit); end
    step();
    vecs++; if (cm_valid !== 2'b00 || count !== 5'd0) begin errs++; $display("FAIL mid_held: got %b %0d want 00 0", cm_valid, count); end
    clear_in();
    rstn = 1;
  endtask
`ifdef ROB_EXT_FLUSH_EN
  task automatic test_ext_flush();
    do_reset();
    alloc(32'h700, 5'd1, 1'b1);
    alloc(32'h704, 5'd2, 1'b1);
    flush = 1;
    #1;
    vecs++; if (alloc_ready !== 1'b0) begin errs++; $display("FAIL ext_ready: got %0b want 0", alloc_ready); end
    step();
    flush = 0;
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL ext_count: got %0d want 0", count); end
  endtask
`endif
  initial begin
    clear_in();
    test_reset();
    test_fill();
    test_dual_commit();
    test_taken_branch();
    test_hazard();
    test_stale_wb();
    test_reset_mid();
`ifdef ROB_EXT_FLUSH_EN
    test_ext_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
